// File: rtl/quadrature_position_decoder.sv
// Quadrature encoder front end: synchronizes and de-glitches A/B/I, tracks the
// electrical cycle position, and measures signed velocity per fixed window.
module quadrature_position_decoder #(
    parameter int COUNTS_PER_CYCLE = 1170,
    parameter int FILTER_LEN       = 3,
    parameter int VEL_WINDOW       = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        enc_a,
    input  logic        enc_b,
    input  logic        enc_i,
    input  logic        clear_error,
    output logic [12:0] cycle_position,
    output logic        direction,
    output logic        step_valid,
    output logic [15:0] velocity,
    output logic        velocity_valid,
    output logic        error_sticky
);

    localparam logic [12:0] POS_MAX   = 13'(COUNTS_PER_CYCLE - 1);
    localparam logic [3:0]  FILT_LAST = 4'(FILTER_LEN - 1);
    localparam logic [4:0]  INIT_LAST = 5'(FILTER_LEN + 2);
    localparam int          WIN_W     = (VEL_WINDOW > 2) ? $clog2(VEL_WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(VEL_WINDOW - 1);

    typedef enum logic {
        ST_INIT,
        ST_TRACK
    } state_t;

    // Bit order everywhere: [2]=index, [1]=A, [0]=B
    logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic       idx_prev_q, idx_prev_d;
    logic       idx_rise;
    logic [1:0] filt_ab;

    always_comb begin
        sync1_d    = {enc_i, enc_a, enc_b};
        sync2_d    = sync1_q;
        idx_prev_d = sync2_q[2];
    end

    assign idx_rise = sync2_q[2] & ~idx_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            idx_prev_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            idx_prev_q <= idx_prev_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_filt
            logic [3:0] cnt_q, cnt_d;
            logic       lvl_q, lvl_d;

            // Count consecutive disagreeing samples; any agreement restarts the run.
            always_comb begin
                cnt_d = '0;
                lvl_d = lvl_q;
                if (sync2_q[gi] != lvl_q) begin
                    if (cnt_q == FILT_LAST) begin
                        lvl_d = sync2_q[gi];
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q <= '0;
                    lvl_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    lvl_q <= lvl_d;
                end
            end

            assign filt_ab[gi] = lvl_q;
        end
    endgenerate

    state_t      state_q, state_d;
    logic [4:0]  init_cnt_q, init_cnt_d;
    logic [1:0]  prev_ab_q, prev_ab_d;
    logic [12:0] pos_q, pos_d;
    logic        dir_q, dir_d;
    logic        step_valid_q, step_valid_d;
    logic        err_q, err_d;
    logic        fwd_move, rev_move, illegal, step_up, step_dn;

    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        prev_ab_d    = prev_ab_q;
        pos_d        = pos_q;
        dir_d        = dir_q;
        step_valid_d = 1'b0;
        err_d        = err_q;
        fwd_move     = 1'b0;
        rev_move     = 1'b0;
        illegal      = 1'b0;
        step_up      = 1'b0;
        step_dn      = 1'b0;
        case (state_q)
            ST_INIT: begin
                // Let the filters settle on the idle levels before trusting them.
                if (init_cnt_q == INIT_LAST) begin
                    prev_ab_d = filt_ab;
                    state_d   = ST_TRACK;
                end else begin
                    init_cnt_d = init_cnt_q + 5'd1;
                end
            end
            ST_TRACK: begin
                prev_ab_d = filt_ab;
                illegal   = ((prev_ab_q ^ filt_ab) == 2'b11);
                case ({prev_ab_q, filt_ab})
                    4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd_move = 1'b1;
                    4'b0100, 4'b1101, 4'b1011, 4'b0010: rev_move = 1'b1;
                    default: ;
                endcase
                if (enable) begin
                    if (fwd_move) begin
                        pos_d        = (pos_q == POS_MAX) ? 13'd0 : pos_q + 13'd1;
                        dir_d        = 1'b1;
                        step_valid_d = 1'b1;
                        step_up      = 1'b1;
                    end else if (rev_move) begin
                        pos_d        = (pos_q == 13'd0) ? POS_MAX : pos_q - 13'd1;
                        dir_d        = 1'b0;
                        step_valid_d = 1'b1;
                        step_dn      = 1'b1;
                    end
                    if (idx_rise) begin
                        pos_d = 13'd0;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
        if (illegal) begin
            err_d = 1'b1;
        end else if (clear_error) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= '0;
            prev_ab_q    <= '0;
            pos_q        <= '0;
            dir_q        <= 1'b0;
            step_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            prev_ab_q    <= prev_ab_d;
            pos_q        <= pos_d;
            dir_q        <= dir_d;
            step_valid_q <= step_valid_d;
            err_q        <= err_d;
        end
    end

    logic [WIN_W-1:0]   win_q, win_d;
    logic signed [16:0] acc_q, acc_d;
    logic signed [16:0] step_amt;
    logic signed [17:0] acc_sum;
    logic signed [15:0] vel_q, vel_d;
    logic               vel_valid_q, vel_valid_d;

    always_comb begin
        step_amt    = step_up ? 17'sd1 : (step_dn ? -17'sd1 : 17'sd0);
        acc_sum     = {acc_q[16], acc_q} + {step_amt[16], step_amt};
        win_d       = '0;
        acc_d       = '0;
        vel_d       = vel_q;
        vel_valid_d = 1'b0;
        if (enable) begin
            if (win_q == WIN_LAST) begin
                // A step landing on the terminal clock opens the next window.
                if (acc_q > 17'sd32767) begin
                    vel_d = 16'sd32767;
                end else if (acc_q < -17'sd32768) begin
                    vel_d = -16'sd32768;
                end else begin
                    vel_d = acc_q[15:0];
                end
                vel_valid_d = 1'b1;
                acc_d       = step_amt;
            end else begin
                win_d = win_q + 1'b1;
                if (acc_sum > 18'sd65535) begin
                    acc_d = 17'sd65535;
                end else if (acc_sum < -18'sd65536) begin
                    acc_d = -17'sd65536;
                end else begin
                    acc_d = acc_sum[16:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q       <= '0;
            acc_q       <= '0;
            vel_q       <= '0;
            vel_valid_q <= 1'b0;
        end else begin
            win_q       <= win_d;
            acc_q       <= acc_d;
            vel_q       <= vel_d;
            vel_valid_q <= vel_valid_d;
        end
    end

    assign cycle_position = pos_q;
    assign direction      = dir_q;
    assign step_valid     = step_valid_q;
    assign velocity       = vel_q;
    assign velocity_valid = vel_valid_q;
    assign error_sticky   = err_q;

endmodule

// File: doc/quadrature_position_decoder.md
Name: quadrature_position_decoder

Overview:
Decodes a motor shaft quadrature encoder (A, B, index) into the 13-bit electrical `cycle_position` that the commutation block consumes. It also reports direction, a signed per-window velocity, and a sticky illegal-transition error. The block sits between the encoder input pins and the commutation/velocity control loop, so it is the sensing end of the same position interface.

Parameters:
- COUNTS_PER_CYCLE, 1170, number of x4 quadrature counts per electrical cycle; `cycle_position` range is 0..COUNTS_PER_CYCLE-1; legal range 2..8192.
- FILTER_LEN, 3, consecutive identical synchronized samples required before a new A/B level is accepted; legal range 1..15.
- VEL_WINDOW, 50000, clocks per velocity measurement window; legal range ≥2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = count and measure; 0 = hold position, clear velocity accumulation.
- enc_a  in  1  encoder channel A, asynchronous to clk.
- enc_b  in  1  encoder channel B, asynchronous to clk.
- enc_i  in  1  encoder index, asynchronous to clk, active-high.
- clear_error  in  1  synchronous clear of error_sticky.
- cycle_position  out  13  electrical position, 0..COUNTS_PER_CYCLE-1.
- direction  out  1  direction of last legal step: 1 = forward, 0 = reverse.
- step_valid  out  1  one-clock pulse coincident with every cycle_position change caused by a step.
- velocity  out  16  signed two's-complement net step count over the last completed window.
- velocity_valid  out  1  one-clock pulse when velocity updates.
- error_sticky  out  1  set on an illegal A/B transition.

Behaviour:
- Reset values: all outputs 0; synchronizers, filters and counters 0; FSM in INIT.
- Synchronization: A, B and I each pass through 2 flops.
- Glitch filter (A and B independently): the filtered level changes only after the synchronized value differs from it for FILTER_LEN consecutive clocks. Any intermediate revert restarts the count.
- Latency: for a clean edge first sampled at clock edge 0, filtered A/B update at edge FILTER_LEN+1 and cycle_position/step_valid at edge FILTER_LEN+2.
- FSM INIT: entered from reset. Waits FILTER_LEN+2 clocks, then captures filtered {A,B} as prev_ab with no count and no error, and moves to TRACK.
- FSM TRACK: each clock compares filtered {A,B} with prev_ab, then prev_ab <= filtered.
  - Forward sequence 00→01→11→10→00: +1, direction <= 1.
  - Reverse sequence: -1, direction <= 0.
  - No change: nothing happens.
  - Both bits changed: illegal. No count, error_sticky <= 1, prev_ab still updated.
- Wrap-around:
  - +1 at COUNTS_PER_CYCLE-1 → 0.
  - -1 at 0 → COUNTS_PER_CYCLE-1.
  - No intermediate value is ever output.
- Index: a rising edge of synchronized I (not glitch-filtered) forces cycle_position <= 0 on the next edge.
  - Index plus a simultaneous step: index wins, position = 0, and step_valid and direction still reflect the step.
  - Index is ignored in INIT and when enable = 0.
- enable = 0:
  - cycle_position and direction hold; step_valid = 0.
  - prev_ab keeps tracking, so re-enable causes no false step.
  - Velocity accumulator and window counter clear and hold at 0; velocity holds its last value.
  - error detection remains active.
- Velocity:
  - The window counter counts 0..VEL_WINDOW-1.
  - On the terminal count, velocity <= accumulator saturated to [-32768, +32767], velocity_valid pulses, and the accumulator restarts.
  - A step occurring on the terminal-count clock belongs to the next window.
  - The accumulator is 17 bits or wider and saturates internally rather than wrapping.
- Error: clear_error clears error_sticky. A simultaneous new illegal transition takes priority (stays 1).
- Reset mid-operation: all state returns to reset values immediately (asynchronous), and the FSM re-enters INIT.

Test Plan:
- Reset, hold A=B=0, enable=1, apply 4 forward edges spaced 10 clocks apart → cycle_position 1,2,3,4, each appearing exactly FILTER_LEN+2=5 clocks after the edge; step_valid pulses 4 times; direction=1; error_sticky=0.
- Preload position 1169 via forward steps, then 1 forward step → 0; then 1 reverse step → 1169, direction=0.
- A pulses high for 2 clocks (FILTER_LEN=3) → no position change, no step_valid, no error.
- Set AB from 00 to 11 simultaneously → error_sticky=1, position unchanged; assert clear_error with no new error → error_sticky=0 next clock.
- VEL_WINDOW=100, 7 forward steps within one window, then 3 reverse steps in the next → velocity=+7 then -3, velocity_valid one clock each at window ends; a step on the terminal clock is counted in the following window.
- Position 500, enc_i rising together with a forward step → position 0, step_valid=1; with enable=0, steps and index → position held, no step_valid; re-enable → no spurious step.
